// File: rtl/md_controller.sv
// md_controller: HI/LO multiply/divide unit for the E stage of a 5-stage pipeline.
// Results are computed combinationally when an op is accepted. They are held in
// pending registers for a fixed number of busy cycles, then committed to HI/LO.
// This gives a deterministic, cycle-accurate latency to the pipeline.
module md_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        d_md_use,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   // FSM encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;

   // Operation codes
   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   // Busy-cycle counter preloads; the commit happens in the cycle where cnt reaches 0
   localparam logic [3:0] MUL_CNT = 4'd4;
   localparam logic [3:0] DIV_CNT = 4'd9;

   logic [1:0]  state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic        busy_reg, busy_next;
   logic [31:0] hi_reg, hi_next;
   logic [31:0] lo_reg, lo_next;
   logic [31:0] pend_hi_reg, pend_hi_next;
   logic [31:0] pend_lo_reg, pend_lo_next;
   // Cleared for a divide by zero so the op runs its full length but commits nothing
   logic        pend_wr_reg, pend_wr_next;

   // ------------------------------------------------------------------
   // Arithmetic datapath
   // ------------------------------------------------------------------
   // op[0]=0 selects the signed flavour for both mult/multu and div/divu
   logic        signed_op;
   logic signed [63:0] prod_s;
   logic [63:0] prod_u;
   logic [63:0] prod;

   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] b_safe;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] quot;
   logic [31:0] rem;
   logic        b_zero;

   assign signed_op = ~op[0];

   assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign prod_u = {32'd0, a} * {32'd0, b};
   assign prod   = signed_op ? prod_s : prod_u;

   // Signed division is done on magnitudes and then re-signed. The quotient
   // truncates toward zero and the remainder follows the dividend's sign.
   // 0x80000000 / -1 folds naturally to quotient 0x80000000, remainder 0.
   assign a_mag  = (signed_op && a[31]) ? (32'd0 - a) : a;
   assign b_mag  = (signed_op && b[31]) ? (32'd0 - b) : b;
   assign b_zero = (b == 32'd0);
   // Keep the divider well-defined for b=0; the result is discarded anyway
   assign b_safe = b_zero ? 32'd1 : b_mag;
   assign q_mag  = a_mag / b_safe;
   assign r_mag  = a_mag % b_safe;
   assign quot   = (signed_op && (a[31] ^ b[31])) ? (32'd0 - q_mag) : q_mag;
   assign rem    = (signed_op && a[31]) ? (32'd0 - r_mag) : r_mag;

   // ------------------------------------------------------------------
   // Control
   // ------------------------------------------------------------------
   // Next-state logic: accept ops in IDLE, count down while busy, commit at zero
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      busy_next    = busy_reg;
      hi_next      = hi_reg;
      lo_next      = lo_reg;
      pend_hi_next = pend_hi_reg;
      pend_lo_next = pend_lo_reg;
      pend_wr_next = pend_wr_reg;

      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
                     pend_hi_next = prod[63:32];
                     pend_lo_next = prod[31:0];
                     pend_wr_next = 1'b1;
                     cnt_next     = MUL_CNT;
                     busy_next    = 1'b1;
                     state_next   = ST_MUL;
                  end
                  OP_DIV, OP_DIVU: begin
                     pend_hi_next = rem;
                     pend_lo_next = quot;
                     pend_wr_next = ~b_zero;
                     cnt_next     = DIV_CNT;
                     busy_next    = 1'b1;
                     state_next   = ST_DIV;
                  end
                  OP_MTHI: hi_next = a;
                  OP_MTLO: lo_next = a;
                  default: ; // 110/111 are no-ops
               endcase
            end
         end

         ST_MUL, ST_DIV: begin
            // start is deliberately ignored here so the pending result is untouched
            if (cnt_reg == 4'd0) begin
               if (pend_wr_reg) begin
                  hi_next = pend_hi_reg;
                  lo_next = pend_lo_reg;
               end
               busy_next  = 1'b0;
               state_next = ST_IDLE;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end

         default: begin
            busy_next  = 1'b0;
            cnt_next   = 4'd0;
            state_next = ST_IDLE;
         end
      endcase
   end

   // State registers with asynchronous active-low clear (reset aborts any op)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= 4'd0;
         busy_reg    <= 1'b0;
         hi_reg      <= 32'd0;
         lo_reg      <= 32'd0;
         pend_hi_reg <= 32'd0;
         pend_lo_reg <= 32'd0;
         pend_wr_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         busy_reg    <= busy_next;
         hi_reg      <= hi_next;
         lo_reg      <= lo_next;
         pend_hi_reg <= pend_hi_next;
         pend_lo_reg <= pend_lo_next;
         pend_wr_reg <= pend_wr_next;
      end
   end

   // Freeze the pipeline if the D-stage instruction needs HI/LO while a
   // multiply/divide is in flight or is being launched this cycle
   assign stall = d_md_use & (busy_reg | (start & ~op[2]));

   assign busy = busy_reg;
   assign hi   = hi_reg;
   assign lo   = lo_reg;

endmodule

// File: tb/tb_md_controller.sv
// tb_md_controller: directed + randomized bench for md_controller with a
// transaction-level reference model (busy-cycle countdown and 64-bit arithmetic).
`timescale 1ns/1ps
module tb_md_controller;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        d_md_use;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   int num_checks = 0;
   int num_errors = 0;

   // Reference model state
   logic [31:0] m_hi, m_lo, m_phi, m_plo;
   logic        m_pwr;
   int          m_left;

   md_controller dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .d_md_use (d_md_use),
      .busy     (busy),
      .stall    (stall),
      .hi       (hi),
      .lo       (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic check_value(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      num_checks++;
      if (observed !== expected) begin
         num_errors++;
         $display("FAIL %s: observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic model_reset();
      m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pwr = 0; m_left = 0;
   endtask

   // One clock edge of the model, using the inputs that were applied before it
   task automatic model_edge();
      longint      sa, sb, q, r, p;
      logic [63:0] pu;
      if (m_left > 0) begin
         m_left--;
         if (m_left == 0 && m_pwr) begin
            m_hi = m_phi;
            m_lo = m_plo;
         end
      end else if (start) begin
         case (op)
            3'd0: begin
               sa = $signed(a); sb = $signed(b); p = sa * sb;
               m_phi = p[63:32]; m_plo = p[31:0]; m_pwr = 1; m_left = 5;
            end
            3'd1: begin
               pu = {32'd0, a} * {32'd0, b};
               m_phi = pu[63:32]; m_plo = pu[31:0]; m_pwr = 1; m_left = 5;
            end
            3'd2, 3'd3: begin
               if (op == 3'd2) begin sa = $signed(a); sb = $signed(b); end
               else begin sa = {32'd0, a}; sb = {32'd0, b}; end
               m_left = 10;
               m_pwr  = (b != 0);
               if (b != 0) begin
                  q = sa / sb; r = sa % sb;
                  m_plo = q[31:0]; m_phi = r[31:0];
               end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
         endcase
      end
   endtask

   task automatic drive(input logic s, input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb, input logic u);
      start = s; op = o; a = va; b = vb; d_md_use = u;
   endtask

   // Check stall before the edge, advance one clock, then check registered outputs
   task automatic cycle();
      logic exp_stall;
      #1;
      exp_stall = d_md_use & ((m_left > 0) | (start & ~op[2]));
      check_value("stall", {63'd0, stall}, {63'd0, exp_stall});
      @(posedge clk);
      model_edge();
      #1;
      check_value("busy", {63'd0, busy}, {63'd0, (m_left > 0)});
      check_value("hi", {32'd0, hi}, {32'd0, m_hi});
      check_value("lo", {32'd0, lo}, {32'd0, m_lo});
   endtask

   // Issue an op for one cycle, then idle until the model says it is done
   task automatic run_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb, input string name);
      int busy_cycles;
      drive(1, o, va, vb, 0);
      cycle();
      drive(0, 3'd7, 0, 0, 0);
      busy_cycles = (m_left > 0) ? 1 : 0;
      for (int i = 0; i < 20 && m_left > 0; i++) begin
         cycle();
         if (busy) busy_cycles++;
      end
      $display("op=%s a=0x%08h b=0x%08h busy_cycles=%0d hi=0x%08h lo=0x%08h", name, va, vb, busy_cycles, hi, lo);
   endtask

   initial begin
      model_reset();
      reset = 1'b0;
      drive(0, 3'd7, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      check_value("reset_busy", {63'd0, busy}, 64'd0);
      check_value("reset_hi", {32'd0, hi}, 64'd0);
      check_value("reset_lo", {32'd0, lo}, 64'd0);
      reset = 1'b1;

      // Multiply examples
      run_op(3'd0, 32'hFFFFFFFF, 32'd2, "mult");
      check_value("mult_hi", {32'd0, hi}, 64'hFFFFFFFF);
      check_value("mult_lo", {32'd0, lo}, 64'hFFFFFFFE);
      run_op(3'd1, 32'hFFFFFFFF, 32'd2, "multu");
      check_value("multu_hi", {32'd0, hi}, 64'h1);
      check_value("multu_lo", {32'd0, lo}, 64'hFFFFFFFE);

      // Divide examples
      run_op(3'd2, 32'hFFFFFFF9, 32'd2, "div");
      check_value("div_lo", {32'd0, lo}, 64'hFFFFFFFD);
      check_value("div_hi", {32'd0, hi}, 64'hFFFFFFFF);
      run_op(3'd3, 32'd7, 32'd2, "divu");
      check_value("divu_lo", {32'd0, lo}, 64'd3);
      check_value("divu_hi", {32'd0, hi}, 64'd1);

      // Divide by zero leaves HI/LO alone after 10 busy cycles
      run_op(3'd4, 32'h11, 0, "mthi");
      run_op(3'd5, 32'h22, 0, "mtlo");
      run_op(3'd3, 32'd1234, 32'd0, "divu0");
      check_value("div0_hi", {32'd0, hi}, 64'h11);
      check_value("div0_lo", {32'd0, lo}, 64'h22);

      // Starts while busy are ignored; stall follows d_md_use while busy
      drive(1, 3'd0, 32'd3, 32'd5, 1);
      cycle();
      drive(0, 3'd7, 0, 0, 1);
      cycle();
      drive(1, 3'd2, 32'd100, 32'd7, 1);
      cycle();
      drive(1, 3'd4, 32'hDEAD, 0, 1);
      cycle();
      drive(0, 3'd7, 0, 0, 1);
      for (int i = 0; i < 10 && m_left > 0; i++) cycle();
      check_value("ignored_hi", {32'd0, hi}, 64'd0);
      check_value("ignored_lo", {32'd0, lo}, 64'd15);
      $display("op=mult_with_ignored_starts hi=0x%08h lo=0x%08h", hi, lo);

      // Reset mid-divide aborts with no commit, asynchronously
      drive(1, 3'd3, 32'd99, 32'd4, 0);
      cycle();
      drive(0, 3'd7, 0, 0, 0);
      repeat (5) cycle();
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check_value("async_busy", {63'd0, busy}, 64'd0);
      check_value("async_hi", {32'd0, hi}, 64'd0);
      check_value("async_lo", {32'd0, lo}, 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      run_op(3'd5, 32'h5, 0, "mtlo_after_reset");
      check_value("post_reset_lo", {32'd0, lo}, 64'h5);
      check_value("post_reset_busy", {63'd0, busy}, 64'd0);

      // Signed overflow divide and mthi with stall low
      run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
      check_value("ovf_lo", {32'd0, lo}, 64'h80000000);
      check_value("ovf_hi", {32'd0, hi}, 64'd0);
      drive(1, 3'd4, 32'hABCD, 0, 1);
      cycle();
      drive(0, 3'd7, 0, 0, 0);
      check_value("mthi_hi", {32'd0, hi}, 64'hABCD);
      check_value("mthi_stall_low", {63'd0, busy}, 64'd0);
      $display("op=mthi a=0x0000abcd hi=0x%08h", hi);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         logic [31:0] ra, rb;
         case ($urandom_range(0, 4))
            0: ra = 32'h80000000;
            1: ra = 32'hFFFFFFFF;
            2: ra = $urandom_range(0, 20);
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: rb = 32'hFFFFFFFF;
            2: rb = $urandom_range(1, 9);
            default: rb = $urandom;
         endcase
         drive(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), ra, rb, 1'($urandom_range(0, 1)));
         cycle();
         if (start && m_left == 0 && op[2] == 1'b0) ; // no-op to keep structure simple
         if (i % 100 == 0)
            $display("random cycle=%0d busy=%0b hi=0x%08h lo=0x%08h", i, busy, hi, lo);
      end

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
